// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the 7-segment scan capture path.
// Pure declarations and helper functions; no timing or flow control.
package seg_pkg;

    // Widest dig_sel the helper functions accept; NUM_DIGITS must not exceed this.
    localparam int MAX_DIGITS = 32;
    localparam int IDX_W      = $clog2(MAX_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit order g..a, indexed by hex value.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [MAX_DIGITS-1:0] v);
        logic [MAX_DIGITS-1:0] one;
        one = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-low 7-segment pattern to hex nibble decoder.
// Zero latency; no flow control.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        nibble = '0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == GLYPH_TABLE[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

    assign blank = (seg_n == SEG_BLANK);

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers per-digit hex values from a multiplexed active-low 7-seg bus once a pattern is stable.
// Outputs land STABLE_CYCLES+1 edges after the sampling edge; passive monitor, no backpressure.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    bad_pattern
);

    localparam int               CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]              s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [NUM_DIGITS-1:0]   s_sel_q, s_sel_d, p_sel_q, p_sel_d;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic                    bad_q, bad_d;

    logic [MAX_DIGITS-1:0]   sel_ext;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_ok;
    logic                    change;
    logic                    accept;
    logic [3:0]              dec_nib;
    logic                    dec_hit;
    logic                    dec_blank;

    always_comb begin
        s_seg_d = seg_n;
        s_sel_d = dig_sel;
        p_seg_d = s_seg_q;
        p_sel_d = s_sel_q;
    end

    // Sampling pipeline keeps running through reset, so a pair held across
    // reset release already counts as unchanged on the first free cycle.
    always_ff @(posedge clock) begin
        s_seg_q <= s_seg_d;
        s_sel_q <= s_sel_d;
        p_seg_q <= p_seg_d;
        p_sel_q <= p_sel_d;
    end

    always_comb begin
        sel_ext                   = '0;
        sel_ext[NUM_DIGITS-1:0]   = s_sel_q;
    end

    assign sel_ok  = is_onehot(sel_ext);
    assign sel_idx = onehot_to_index(sel_ext);
    assign change  = (s_seg_q != p_seg_q) || (s_sel_q != p_sel_q);

    seg7_to_hex u_dec (
        .seg_n  (s_seg_q),
        .nibble (dec_nib),
        .hit    (dec_hit),
        .blank  (dec_blank)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_ok) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (change) begin
                    cnt_d   = '0;
                    state_d = sel_ok ? SETTLE : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (change) begin
                    cnt_d   = '0;
                    state_d = sel_ok ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hex_d    = hex_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        bad_d    = 1'b0;
        if (accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IDX_W'(i) == sel_idx) begin
                    if (dec_hit) begin
                        hex_d[4*i +: 4] = dec_nib;
                        valid_d[i]      = 1'b1;
                        update_d        = !valid_q[i] || (hex_q[4*i +: 4] != dec_nib);
                    end else begin
                        // Blank or illegal: the last good nibble stays visible but is flagged invalid.
                        valid_d[i] = 1'b0;
                        update_d   = valid_q[i];
                        bad_d      = !dec_blank;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hex_q    <= '0;
            valid_q  <= '0;
            update_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            hex_q    <= hex_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            bad_q    <= bad_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign bad_pattern = bad_q;

endmodule
